height_history_recorder: RTL and testbench
==========================================

Name: height_history_recorder

Overview:
Writer side of the 10-entry height history. Captures a stable height reading into a newest-first shift history (hist_0 newest … hist_9 oldest) when the user presses the save button. The registers feed the history viewer and the display path directly. Sits between the ultrasonic height-measurement block, which supplies height_in/height_valid, and the history display.

Parameters:
DEBOUNCE_CYCLES, 1048576, cycles the synchronized button must differ from its stable value before it is accepted (~87 ms at 12 MHz).
STABLE_SAMPLES, 4, consecutive in-tolerance samples required before a commit (range 1..15).
TOLERANCE, 1, maximum |sample − run reference| in inches that still counts as stable.
TIMEOUT_CYCLES, 24000000, cycles an armed save waits before aborting (2 s at 12 MHz).

Ports:
clk  in  1  system clock (~12 MHz)
reset_n  in  1  asynchronous active-low reset
save_btn  in  1  raw save button, active-low, asynchronous to clk
clear  in  1  synchronous level; wipes history
height_in  in  8  measured height, inches; 0 = no echo/invalid
height_valid  in  1  one-cycle strobe; height_in is valid this cycle
hist_0 … hist_9  out  8 each  saved heights, hist_0 newest
entry_count  out  4  number of valid entries, saturates at 10
busy  out  1  high while a save is armed or committing
saved  out  1  one-cycle pulse on commit
save_fail  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, reset_n=0):
  - hist_0..9=0, entry_count=0, busy=0, saved=0, save_fail=0.
  - FSM=IDLE, all counters=0.
  - Button synchronizer flops, stable and prev button = 1.
- Button path:
  - 2-flop synchronizer, then debounce.
  - Counter increments while sync != stable and clears to 0 when they are equal.
  - When counter == DEBOUNCE_CYCLES−1 and still differing: stable <= sync, counter <= 0.
  - press = prev & ~stable, a one-cycle pulse; prev <= stable every cycle.
- FSM states IDLE, ARMED, COMMIT:
  - IDLE: on press → ARMED. On entry to ARMED: timer=0, run count=0, ref cleared.
  - ARMED, per height_valid:
    - height_in==0 → run count=0, ref cleared.
    - Run count==0 → ref=height_in, run count=1.
    - |height_in − ref| <= TOLERANCE → run count+1.
    - Otherwise → ref=height_in, run count=1.
    - When the updated run count reaches STABLE_SAMPLES, latch the commit value (the current height_in) and go to COMMIT.
    - STABLE_SAMPLES=1 commits on the first nonzero sample.
  - ARMED timer:
    - Timer increments every cycle.
    - At TIMEOUT_CYCLES−1 → IDLE and save_fail=1 for one cycle.
    - If a qualifying sample arrives in the same cycle as the timeout, the commit wins.
  - COMMIT, one cycle: shift hist_k <= hist_(k−1) for k=9..1, hist_0 <= commit value, entry_count <= min(entry_count+1, 10), → IDLE.
  - saved is registered and is high exactly the first cycle the new hist_0 is visible.
- Commit latency: qualifying height_valid at edge N → state COMMIT after edge N → history updated at edge N+1.
- busy = (state != IDLE).
- Presses during ARMED or COMMIT are ignored; they are not queued.
- Absolute difference is computed at 8 bits unsigned with no wrap, i.e. max−min.
- hist_9 is discarded on shift once full.
- clear:
  - Highest synchronous priority: hist=0, entry_count=0, FSM=IDLE, timer and run counters 0, saved and save_fail=0.
  - A commit in the same cycle is dropped.
  - The debouncer is unaffected.
- Reset mid-operation aborts immediately to reset values; no pulse is emitted.

Decomposition:
- Package height_pkg:
  - HEIGHT_W=8, HIST_DEPTH=10.
  - typedef logic [HEIGHT_W-1:0] height_t.
  - enum hist_state_t {HS_IDLE, HS_ARMED, HS_COMMIT}.
- Sub-module button_debounce:
  - Ports: clk, reset_n, btn_raw; outputs btn_stable, press.
  - Parameter DEBOUNCE_CYCLES.
  - Reusable by the history viewer.
- History storage is an internal height_t array of HIST_DEPTH, mapped onto the hist_k ports.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, STABLE_SAMPLES=3, TOLERANCE=1, TIMEOUT_CYCLES=50.)
1. Assert reset_n=0 mid-run with nonzero history → all hist=0, entry_count=0, busy=0, saved=0 immediately, without waiting for a clock edge.
2. Hold save_btn low 12 cycles, then samples 60, 61, 60 → busy=1 after press; saved pulses once; hist_0=60 the cycle saved=1; entry_count=1; busy=0 next cycle.
3. Armed, samples 60, 65, 0, 65, 66, 65 → sample 0 and the 60→65 jump restart the run; commit value 65; exactly one saved pulse.
4. Eleven saves of values 1..11 → hist_0=11, hist_1=10 … hist_9=2; entry_count stays 10 after the 10th save.
5. Press, then no height_valid for 50 cycles → save_fail high exactly one cycle, busy=0, history and entry_count unchanged. Variant: qualifying sample on the timeout cycle → saved=1, save_fail=0.
6. save_btn low for 2 cycles (glitch) → no press, busy stays 0. Then press, and assert clear while ARMED with the completing sample → all hist=0, entry_count=0, no saved pulse, FSM IDLE.

Source files
------------

// File: rtl/height_pkg.sv
// Shared types for the height history blocks.
//   HEIGHT_W / HIST_DEPTH : sample width and history length
//   height_t              : one height sample in inches
//   hist_state_t          : recorder save-sequence states
//   abs_diff()            : unsigned |a - b| without wrap
package height_pkg;

    localparam int unsigned HEIGHT_W   = 8;
    localparam int unsigned HIST_DEPTH = 10;
    localparam int unsigned RUN_W      = 4;
    localparam int unsigned COUNT_W    = 4;

    typedef logic [HEIGHT_W-1:0] height_t;

    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,
        HS_ARMED  = 2'd1,
        HS_COMMIT = 2'd2
    } hist_state_t;

    // max - min, so the result never wraps
    function automatic height_t abs_diff(input height_t a, input height_t b);
        return (a > b) ? height_t'(a - b) : height_t'(b - a);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces an active-low push button.
//   clk, reset_n : clock, async active-low reset
//   btn_raw      : raw button level, asynchronous to clk
//   btn_stable   : debounced button level (idles high)
//   press        : one-cycle pulse on a debounced high-to-low transition
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_stable,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer, then accept a new level only after it persists
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            btn_stable <= 1'b1;
            prev       <= 1'b1;
            cnt        <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            prev   <= btn_stable;
            if (sync_2 != btn_stable) begin
                if (cnt == CNT_LAST) begin
                    btn_stable <= sync_2;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Derived only from flops, so it is a clean single-cycle pulse
    assign press = prev & ~btn_stable;

endmodule

// File: rtl/height_history_recorder.sv
// Records stable height readings into a newest-first 10-entry history.
//   clk, reset_n          : clock, async active-low reset
//   save_btn              : raw active-low save button
//   clear                 : synchronous history wipe (highest priority)
//   height_in/height_valid: measured height and its one-cycle strobe
//   hist_0..hist_9        : saved heights, hist_0 newest
//   entry_count           : valid entries, saturating at 10
//   busy                  : save armed or committing
//   saved / save_fail     : one-cycle pulses on commit / timeout abort
module height_history_recorder
    import height_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1048576,
    parameter int unsigned STABLE_SAMPLES  = 4,
    parameter int unsigned TOLERANCE       = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 24000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                save_btn,
    input  logic                clear,
    input  logic [HEIGHT_W-1:0] height_in,
    input  logic                height_valid,
    output logic [HEIGHT_W-1:0] hist_0,
    output logic [HEIGHT_W-1:0] hist_1,
    output logic [HEIGHT_W-1:0] hist_2,
    output logic [HEIGHT_W-1:0] hist_3,
    output logic [HEIGHT_W-1:0] hist_4,
    output logic [HEIGHT_W-1:0] hist_5,
    output logic [HEIGHT_W-1:0] hist_6,
    output logic [HEIGHT_W-1:0] hist_7,
    output logic [HEIGHT_W-1:0] hist_8,
    output logic [HEIGHT_W-1:0] hist_9,
    output logic [COUNT_W-1:0]  entry_count,
    output logic                busy,
    output logic                saved,
    output logic                save_fail
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RUN_W-1:0]   RUN_TARGET = RUN_W'(STABLE_SAMPLES);
    localparam height_t            TOL        = HEIGHT_W'(TOLERANCE);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(HIST_DEPTH);

    logic press;
    logic btn_unused;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (save_btn),
        .btn_stable(btn_unused),
        .press     (press)
    );

    hist_state_t                  state, state_nxt;
    logic [TMR_W-1:0]             timer, timer_nxt;
    logic [RUN_W-1:0]             run_cnt, run_nxt, run_upd;
    height_t                      ref_q, ref_nxt, ref_upd;
    height_t                      commit_q, commit_nxt;
    height_t [HIST_DEPTH-1:0]     hist_q, hist_nxt;
    logic [COUNT_W-1:0]           count_nxt;
    logic                         busy_nxt, saved_nxt, fail_nxt;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HS_IDLE;
            timer       <= '0;
            run_cnt     <= '0;
            ref_q       <= '0;
            commit_q    <= '0;
            hist_q      <= '0;
            entry_count <= '0;
            busy        <= 1'b0;
            saved       <= 1'b0;
            save_fail   <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            run_cnt     <= run_nxt;
            ref_q       <= ref_nxt;
            commit_q    <= commit_nxt;
            hist_q      <= hist_nxt;
            entry_count <= count_nxt;
            busy        <= busy_nxt;
            saved       <= saved_nxt;
            save_fail   <= fail_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        run_nxt    = run_cnt;
        ref_nxt    = ref_q;
        run_upd    = run_cnt;
        ref_upd    = ref_q;
        commit_nxt = commit_q;
        hist_nxt   = hist_q;
        count_nxt  = entry_count;
        saved_nxt  = 1'b0;
        fail_nxt   = 1'b0;

        case (state)
            HS_IDLE: begin
                // Holding these at zero gives a clean run on entry to ARMED
                timer_nxt = '0;
                run_nxt   = '0;
                ref_nxt   = '0;
                if (press) begin
                    state_nxt = HS_ARMED;
                end
            end

            HS_ARMED: begin
                timer_nxt = timer + TMR_W'(1);
                if (height_valid) begin
                    if (height_in == '0) begin
                        run_upd = '0;
                        ref_upd = '0;
                    end else if (run_cnt == '0 || abs_diff(height_in, ref_q) > TOL) begin
                        run_upd = RUN_W'(1);
                        ref_upd = height_in;
                    end else begin
                        run_upd = run_cnt + RUN_W'(1);
                    end
                    run_nxt = run_upd;
                    ref_nxt = ref_upd;
                end
                // A qualifying sample beats a simultaneous timeout
                if (height_valid && run_upd == RUN_TARGET) begin
                    commit_nxt = height_in;
                    state_nxt  = HS_COMMIT;
                end else if (timer == TMR_LAST) begin
                    fail_nxt  = 1'b1;
                    state_nxt = HS_IDLE;
                end
            end

            HS_COMMIT: begin
                hist_nxt  = {hist_q[HIST_DEPTH-2:0], commit_q};
                count_nxt = (entry_count == COUNT_MAX) ? entry_count
                                                       : entry_count + COUNT_W'(1);
                saved_nxt = 1'b1;
                state_nxt = HS_IDLE;
            end

            default: begin
                state_nxt = HS_IDLE;
            end
        endcase

        if (clear) begin
            state_nxt = HS_IDLE;
            timer_nxt = '0;
            run_nxt   = '0;
            ref_nxt   = '0;
            hist_nxt  = '0;
            count_nxt = '0;
            saved_nxt = 1'b0;
            fail_nxt  = 1'b0;
        end

        busy_nxt = (state_nxt != HS_IDLE);
    end

    assign hist_0 = hist_q[0];
    assign hist_1 = hist_q[1];
    assign hist_2 = hist_q[2];
    assign hist_3 = hist_q[3];
    assign hist_4 = hist_q[4];
    assign hist_5 = hist_q[5];
    assign hist_6 = hist_q[6];
    assign hist_7 = hist_q[7];
    assign hist_8 = hist_q[8];
    assign hist_9 = hist_q[9];

endmodule

// File: tb/tb_height_history_recorder.sv
// Self-checking bench for height_history_recorder with a queue-based history model.
module tb_height_history_recorder;

    localparam int DEBOUNCE = 4;
    localparam int STABLE   = 3;
    localparam int TOL      = 1;
    localparam int TIMEOUT  = 50;

    logic       clk;
    logic       reset_n;
    logic       save_btn;
    logic       clear;
    logic [7:0] height_in;
    logic       height_valid;
    logic [7:0] hist [10];
    logic [3:0] entry_count;
    logic       busy;
    logic       saved;
    logic       save_fail;

    int checks;
    int errors;
    int model_q[$];
    int stim[$];

    height_history_recorder #(
        .DEBOUNCE_CYCLES(DEBOUNCE),
        .STABLE_SAMPLES (STABLE),
        .TOLERANCE      (TOL),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .save_btn    (save_btn),
        .clear       (clear),
        .height_in   (height_in),
        .height_valid(height_valid),
        .hist_0      (hist[0]),
        .hist_1      (hist[1]),
        .hist_2      (hist[2]),
        .hist_3      (hist[3]),
        .hist_4      (hist[4]),
        .hist_5      (hist[5]),
        .hist_6      (hist[6]),
        .hist_7      (hist[7]),
        .hist_8      (hist[8]),
        .hist_9      (hist[9]),
        .entry_count (entry_count),
        .busy        (busy),
        .saved       (saved),
        .save_fail   (save_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // History as the specification describes it: newest first, at most 10 kept
    task automatic model_push(input int v);
        model_q.push_front(v);
        if (model_q.size() > 10) void'(model_q.pop_back());
    endtask

    task automatic check_hist(input string tag);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s_hist%0d", tag, k), 32'(hist[k]),
                  (k < model_q.size()) ? 32'(model_q[k]) : 32'd0);
        end
        check({tag, "_count"}, 32'(entry_count), 32'(model_q.size()));
    endtask

    // Index and value of the sample that completes a stable run, or -1
    function automatic void find_commit(input int s[$], output int idx, output int val);
        int ref_h;
        int run;
        int d;
        ref_h = 0;
        run   = 0;
        idx   = -1;
        val   = 0;
        foreach (s[i]) begin
            if (idx < 0) begin
                d = (s[i] > ref_h) ? s[i] - ref_h : ref_h - s[i];
                if (s[i] == 0) begin
                    run = 0;
                end else if (run == 0 || d > TOL) begin
                    ref_h = s[i];
                    run   = 1;
                end else begin
                    run++;
                end
                if (run == STABLE) begin
                    idx = i;
                    val = s[i];
                end
            end
        end
    endfunction

    // Press the button and wait (bounded) for the recorder to arm
    task automatic press_save(input string tag);
        bit got;
        save_btn = 1'b1;
        repeat (8) tick();
        save_btn = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (busy === 1'b1) got = 1'b1;
        end
        check({tag, "_armed"}, 32'(busy), 32'd1);
        save_btn = 1'b1;
    endtask

    // One complete save using the samples in stim
    task automatic do_save(input string tag);
        int idx;
        int val;
        press_save(tag);
        find_commit(stim, idx, val);
        for (int i = 0; i <= idx; i++) begin
            height_in    = 8'(stim[i]);
            height_valid = 1'b1;
            tick();
            height_valid = 1'b0;
            height_in    = 8'd0;
            if (i < idx) begin
                check({tag, "_saved_early"}, 32'(saved), 32'd0);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        check({tag, "_busy_commit"}, 32'(busy), 32'd1);
        check({tag, "_saved_pre"}, 32'(saved), 32'd0);
        tick();
        check({tag, "_saved"}, 32'(saved), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        model_push(val);
        check_hist(tag);
        tick();
        check({tag, "_saved_once"}, 32'(saved), 32'd0);
    endtask

    initial begin
        int base;
        int v;
        bit seen_busy;
        checks       = 0;
        errors       = 0;
        save_btn     = 1'b1;
        clear        = 1'b0;
        height_in    = 8'd0;
        height_valid = 1'b0;
        reset_n      = 1'b1;

        // Power-on reset
        #2 reset_n = 1'b0;
        #1;
        check("por_busy", 32'(busy), 32'd0);
        check("por_saved", 32'(saved), 32'd0);
        check("por_fail", 32'(save_fail), 32'd0);
        check_hist("por");
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Basic save 60, 61, 60
        stim = '{60, 61, 60};
        do_save("basic");
        check("basic_hist0", 32'(hist[0]), 32'd60);

        // Zero sample and out-of-tolerance jump restart the run
        stim = '{60, 65, 0, 65, 66, 65};
        do_save("restart");
        check("restart_hist0", 32'(hist[0]), 32'd65);

        // Eleven saves overflow the history
        for (int n = 1; n <= 11; n++) begin
            stim = '{n, n, n};
            do_save($sformatf("fill%0d", n));
        end
        check("fill_hist0", 32'(hist[0]), 32'd11);
        check("fill_hist9", 32'(hist[9]), 32'd2);
        check("fill_count", 32'(entry_count), 32'd10);

        // Randomized sample streams: noisy prefix then a settled value
        for (int r = 0; r < 6; r++) begin
            stim.delete();
            base = $urandom_range(10, 240);
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 5) == 0) stim.push_back(0);
                else stim.push_back(base + $urandom_range(0, 4) - 2);
            end
            v = $urandom_range(10, 240);
            repeat (3) stim.push_back(v);
            do_save($sformatf("rand%0d", r));
        end

        // Timeout with no samples
        press_save("tmo");
        repeat (TIMEOUT - 1) tick();
        check("tmo_fail_early", 32'(save_fail), 32'd0);
        check("tmo_busy_early", 32'(busy), 32'd1);
        tick();
        check("tmo_fail", 32'(save_fail), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_saved", 32'(saved), 32'd0);
        check_hist("tmo");
        tick();
        check("tmo_fail_once", 32'(save_fail), 32'd0);

        // Qualifying sample on the timeout cycle: commit wins
        press_save("race");
        repeat (TIMEOUT - 3) tick();
        v = $urandom_range(1, 255);
        height_in    = 8'(v);
        height_valid = 1'b1;
        repeat (3) tick();
        height_valid = 1'b0;
        height_in    = 8'd0;
        check("race_fail", 32'(save_fail), 32'd0);
        check("race_busy", 32'(busy), 32'd1);
        tick();
        check("race_saved", 32'(saved), 32'd1);
        check("race_fail_late", 32'(save_fail), 32'd0);
        model_push(v);
        check_hist("race");
        tick();

        // Button glitch shorter than the debounce window
        save_btn = 1'b1;
        repeat (8) tick();
        save_btn = 1'b0;
        repeat (2) tick();
        save_btn = 1'b1;
        seen_busy = 1'b0;
        repeat (12) begin
            tick();
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        check("glitch_busy", 32'(seen_busy), 32'd0);

        // Clear in the same cycle as the completing sample
        press_save("clr");
        height_in    = 8'd70;
        height_valid = 1'b1;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear        = 1'b0;
        height_valid = 1'b0;
        height_in    = 8'd0;
        model_q.delete();
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_saved", 32'(saved), 32'd0);
        check_hist("clr");
        tick();
        check("clr_saved_late", 32'(saved), 32'd0);
        check("clr_busy_late", 32'(busy), 32'd0);

        // Asynchronous reset while armed with history present
        stim = '{33, 33, 34};
        do_save("pre_rst");
        press_save("rst");
        #2 reset_n = 1'b0;
        #1;
        model_q.delete();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_saved", 32'(saved), 32'd0);
        check("rst_fail", 32'(save_fail), 32'd0);
        check_hist("rst");
        @(negedge clk) reset_n = 1'b1;
        repeat (3) tick();
        check("rst_busy_after", 32'(busy), 32'd0);
        check("rst_saved_after", 32'(saved), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
